// File: rtl/core_inst_sequencer.sv
// ---------------------------------------------------------------------------
// core_inst_sequencer
//
// Upstream controller for the core. Emits one 35-bit instruction word per
// cycle that drives xmem, L0, IFIFO/OFIFO, the PE array and psum memory for
// one tile pass:
//   kernel load -> kernel push -> activation load -> execute -> output drain.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low (0 = in reset)
//   start        one-cycle pulse, sampled only while idle
//   mode         0 = WS, 1 = OS; latched at start, driven on inst[34]
//   kbase        xmem base address of kernel words
//   abase        xmem base address of activation words
//   pbase        psum memory base address for results
//   act_len      activation vectors / output rows in this pass (0..2047)
//   ofifo_valid  OFIFO holds a complete output row
//   inst         registered instruction word to the core
//   busy         1 while a pass is in progress (DONE included)
//   done         one-cycle pulse at pass completion
//   dbg_state    current FSM state, for checkers
//
// inst map: [34] mode, [33] 0, [32] psum CEN, [31] psum WEN, [30:20] psum addr,
//   [19] xmem CEN, [18] xmem WEN, [17:7] xmem addr, [6] ofifo_rd, [5:4] 0,
//   [3] l0_rd, [2] l0_wr, [1] execute, [0] load.  CEN/WEN are active-low.
//
// OFIFO handshake: ofifo_valid acts as "valid" and the ofifo_rd strobe as
// "ready". A row is transferred in exactly the cycle the sequencer decides
// to read while ofifo_valid is high; ofifo_valid low never produces a read,
// and no more than act_len rows are ever read in one pass.
//
// All outputs are registered, so every word appears on inst one cycle
// after the FSM is in the state that produces it.
// ---------------------------------------------------------------------------
module core_inst_sequencer #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [addr_bw-1:0] kbase,
  input  logic [addr_bw-1:0] abase,
  input  logic [addr_bw-1:0] pbase,
  input  logic [addr_bw-1:0] act_len,
  input  logic               ofifo_valid,
  output logic [34:0]        inst,
  output logic               busy,
  output logic               done,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_KLOAD, S_KPUSH, S_ALOAD, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  // One extra bit so act_len+1 cycle counts and row/col sums never overflow.
  localparam int CW = addr_bw + 1;
  localparam logic [CW-1:0] COL_C      = CW'(col);
  localparam logic [CW-1:0] KPUSH_LAST = CW'(col + row - 1);
  localparam logic [34:0]   IDLE_WORD  = {4'b0011, 11'b0, 2'b11, 11'b0, 7'b0};

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]      wr_cnt_q, wr_cnt_d;
  logic               wr_pend_q, wr_pend_d;
  logic               mode_q, mode_d;
  logic [addr_bw-1:0] kbase_q, kbase_d, abase_q, abase_d, pbase_q, pbase_d;
  logic [addr_bw-1:0] act_len_q, act_len_d;
  logic [34:0]        inst_q, inst_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic               psum_cen, psum_wen, xmem_cen, xmem_wen;
  logic [addr_bw-1:0] psum_addr, xmem_addr;
  logic               ofifo_rd, l0_rd, l0_wr, execute, load;
  logic [CW-1:0]      len_x;

  assign len_x = {1'b0, act_len_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    wr_pend_d = 1'b0;
    mode_d    = mode_q;
    kbase_d   = kbase_q;
    abase_d   = abase_q;
    pbase_d   = pbase_q;
    act_len_d = act_len_q;
    psum_cen  = 1'b1;
    psum_wen  = 1'b1;
    psum_addr = '0;
    xmem_cen  = 1'b1;
    xmem_wen  = 1'b1;
    xmem_addr = '0;
    ofifo_rd  = 1'b0;
    l0_rd     = 1'b0;
    l0_wr     = 1'b0;
    execute   = 1'b0;
    load      = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          mode_d    = mode;
          kbase_d   = kbase;
          abase_d   = abase;
          pbase_d   = pbase;
          act_len_d = act_len;
          state_d   = (act_len == '0) ? S_DONE : S_KLOAD;
        end
      end
      // xmem reads have one cycle of latency, so l0_wr trails the read by one.
      S_KLOAD: begin
        if (cnt_q < COL_C) begin
          xmem_cen  = 1'b0;
          xmem_addr = kbase_q + cnt_q[addr_bw-1:0];
        end
        l0_wr = (cnt_q != '0);
        if (cnt_q == COL_C) begin
          state_d = S_KPUSH;
          cnt_d   = '0;
        end
      end
      S_KPUSH: begin
        load  = 1'b1;
        l0_rd = (cnt_q < COL_C);
        if (cnt_q == KPUSH_LAST) begin
          state_d = S_ALOAD;
          cnt_d   = '0;
        end
      end
      S_ALOAD: begin
        if (cnt_q < len_x) begin
          xmem_cen  = 1'b0;
          xmem_addr = abase_q + cnt_q[addr_bw-1:0];
        end
        l0_wr = (cnt_q != '0);
        if (cnt_q == len_x) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end
      end
      S_EXEC: begin
        execute = 1'b1;
        l0_rd   = 1'b1;
        if (cnt_q == len_x - CW'(1)) begin
          state_d  = S_DRAIN;
          cnt_d    = '0;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
        end
      end
      // A row read in one cycle is written to psum the next; the write of a
      // pending row still issues while ofifo_valid stalls further reads.
      S_DRAIN: begin
        cnt_d = '0;
        if (ofifo_valid && (rd_cnt_q < len_x)) begin
          ofifo_rd  = 1'b1;
          rd_cnt_d  = rd_cnt_q + CW'(1);
          wr_pend_d = 1'b1;
        end
        if (wr_pend_q) begin
          psum_cen  = 1'b0;
          psum_wen  = 1'b0;
          psum_addr = pbase_q + wr_cnt_q[addr_bw-1:0];
          wr_cnt_d  = wr_cnt_q + CW'(1);
          if (wr_cnt_q + CW'(1) == len_x) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_q != S_IDLE);
    inst_d = {mode_q, 1'b0, psum_cen, psum_wen, psum_addr, xmem_cen, xmem_wen,
              xmem_addr, ofifo_rd, 2'b00, l0_rd, l0_wr, execute, load};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      wr_pend_q <= 1'b0;
      mode_q    <= 1'b0;
      kbase_q   <= '0;
      abase_q   <= '0;
      pbase_q   <= '0;
      act_len_q <= '0;
      inst_q    <= IDLE_WORD;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_pend_q <= wr_pend_d;
      mode_q    <= mode_d;
      kbase_q   <= kbase_d;
      abase_q   <= abase_d;
      pbase_q   <= pbase_d;
      act_len_q <= act_len_d;
      inst_q    <= inst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign inst      = inst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_core_inst_sequencer
//
// Bench for core_inst_sequencer. A reference model builds the full expected
// per-cycle instruction trace of a pass from the phase lengths and the
// ofifo_valid pattern; run_pass compares it cycle by cycle. Directed
// vectors add hand-derived totals and address endpoints; a hand sequence
// covers reset mid-pass and start while busy.
// ---------------------------------------------------------------------------
module tb_core_inst_sequencer;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam logic [34:0] IDLE_W = 35'h1_800C_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic [AW-1:0] kbase, abase, pbase, act_len;
  logic          ofifo_valid;
  logic [34:0]   inst;
  logic          busy, done;
  logic [2:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  bit valid_pat [512];
  logic [34:0] exp_q[$];

  typedef struct {
    logic          m;
    logic [AW-1:0] kb, ab, pb, len;
    int            stall;
    int            exp_total;
    int            exp_nx;
    int            exp_np;
    logic [AW-1:0] exp_last_x, exp_first_p, exp_last_p;
  } vec_t;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  core_inst_sequencer #(.row(ROW), .col(COL), .addr_bw(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .kbase(kbase), .abase(abase), .pbase(pbase), .act_len(act_len),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [34:0] idle_word(input logic m);
    logic [34:0] w;
    w = IDLE_W;
    w[34] = m;
    return w;
  endfunction

  // Reference model: expected inst word for each cycle after the start edge.
  task automatic build_model(input logic m, input logic [AW-1:0] kb, ab, pb, len);
    logic [34:0]   w;
    logic [AW-1:0] a;
    int rd_cyc[$];
    int base, c, last;
    exp_q.delete();
    if (len != 0) begin
      for (int i = 0; i <= COL; i++) begin
        w = idle_word(m);
        if (i < COL) begin w[19] = 1'b0; a = kb + AW'(i); w[17:7] = a; end
        if (i > 0) w[2] = 1'b1;
        exp_q.push_back(w);
      end
      for (int i = 0; i < COL + ROW; i++) begin
        w = idle_word(m);
        w[0] = 1'b1;
        if (i < COL) w[3] = 1'b1;
        exp_q.push_back(w);
      end
      for (int i = 0; i <= int'(len); i++) begin
        w = idle_word(m);
        if (i < int'(len)) begin w[19] = 1'b0; a = ab + AW'(i); w[17:7] = a; end
        if (i > 0) w[2] = 1'b1;
        exp_q.push_back(w);
      end
      for (int i = 0; i < int'(len); i++) begin
        w = idle_word(m);
        w[1] = 1'b1;
        w[3] = 1'b1;
        exp_q.push_back(w);
      end
      // Rows are read on the first len drain cycles with ofifo_valid high,
      // each written to psum on the following cycle.
      base = exp_q.size();
      c = base;
      while (rd_cyc.size() < int'(len) && c < 512) begin
        if (valid_pat[c]) rd_cyc.push_back(c);
        c++;
      end
      last = rd_cyc[rd_cyc.size()-1];
      for (int cc = base; cc <= last + 1; cc++) begin
        w = idle_word(m);
        foreach (rd_cyc[j]) begin
          if (rd_cyc[j] == cc) w[6] = 1'b1;
          if (rd_cyc[j] + 1 == cc) begin
            w[32] = 1'b0;
            w[31] = 1'b0;
            a = pb + AW'(j);
            w[30:20] = a;
          end
        end
        exp_q.push_back(w);
      end
    end
    exp_q.push_back(idle_word(m));
  endtask

  // ---------------- driver ----------------
  task automatic run_pass(input logic m, input logic [AW-1:0] kb, ab, pb, len,
                          input string tag, output int total, output int n_x,
                          output int n_p, output logic [AW-1:0] last_x,
                          output logic [AW-1:0] first_p, output logic [AW-1:0] last_p);
    logic [34:0] w;
    int n_exp, done_at;
    build_model(m, kb, ab, pb, len);
    n_exp = exp_q.size();
    done_at = -1;
    n_x = 0; n_p = 0; last_x = '0; first_p = '0; last_p = '0;
    @(negedge clk);
    mode = m; kbase = kb; abase = ab; pbase = pb; act_len = len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Config changes while busy must have no effect.
    mode = ~m; kbase = AW'($urandom); abase = AW'($urandom);
    pbase = AW'($urandom); act_len = AW'($urandom);
    for (int c = 0; c < n_exp; c++) begin
      ofifo_valid = valid_pat[c];
      @(posedge clk); #1;
      w = exp_q.pop_front();
      check($sformatf("%s inst c%0d", tag, c), inst, w);
      check($sformatf("%s busy c%0d", tag, c), 35'(busy), 35'(1));
      check($sformatf("%s done c%0d", tag, c), 35'(done), 35'(c == n_exp - 1));
      if (done && done_at < 0) done_at = c;
      if (!inst[19]) begin n_x++; last_x = inst[17:7]; end
      if (!inst[32]) begin
        if (n_p == 0) first_p = inst[30:20];
        n_p++;
        last_p = inst[30:20];
      end
    end
    ofifo_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, " idle inst"}, inst, idle_word(m));
    check({tag, " idle busy"}, 35'(busy), 35'(0));
    check({tag, " idle done"}, 35'(done), 35'(0));
    total = done_at + 1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t vt[4];
    int total, n_x, n_p, d0, done_cnt, first_done;
    logic [AW-1:0] last_x, first_p, last_p;

    vt[0] = '{m:1'b0, kb:11'd0,   ab:11'd16,   pb:11'd100,  len:11'd4, stall:0,
              exp_total:40, exp_nx:12, exp_np:4,
              exp_last_x:11'd19,  exp_first_p:11'd100,  exp_last_p:11'd103};
    vt[1] = '{m:1'b1, kb:11'd5,   ab:11'd6,    pb:11'd7,    len:11'd0, stall:0,
              exp_total:1,  exp_nx:0,  exp_np:0,
              exp_last_x:11'd0,   exp_first_p:11'd0,    exp_last_p:11'd0};
    vt[2] = '{m:1'b1, kb:11'd200, ab:11'd300,  pb:11'd400,  len:11'd4, stall:5,
              exp_total:45, exp_nx:12, exp_np:4,
              exp_last_x:11'd303, exp_first_p:11'd400,  exp_last_p:11'd403};
    vt[3] = '{m:1'b0, kb:11'd10,  ab:11'd2046, pb:11'd2047, len:11'd4, stall:0,
              exp_total:40, exp_nx:12, exp_np:4,
              exp_last_x:11'd1,   exp_first_p:11'd2047, exp_last_p:11'd2};

    reset = 1'b0; start = 1'b0; mode = 1'b0; ofifo_valid = 1'b0;
    kbase = '0; abase = '0; pbase = '0; act_len = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset inst", inst, IDLE_W);
    check("reset busy", 35'(busy), 35'(0));
    check("reset done", 35'(done), 35'(0));
    @(negedge clk);
    reset = 1'b1;

    // Directed vectors
    for (int v = 0; v < 4; v++) begin
      d0 = 2 * COL + ROW + 2 + 2 * int'(vt[v].len);
      for (int c = 0; c < 512; c++) valid_pat[c] = !(c >= d0 && c < d0 + vt[v].stall);
      run_pass(vt[v].m, vt[v].kb, vt[v].ab, vt[v].pb, vt[v].len, $sformatf("vec%0d", v),
               total, n_x, n_p, last_x, first_p, last_p);
      check($sformatf("vec%0d total", v),   35'(total),   35'(vt[v].exp_total));
      check($sformatf("vec%0d n_xmem", v),  35'(n_x),     35'(vt[v].exp_nx));
      check($sformatf("vec%0d n_psum", v),  35'(n_p),     35'(vt[v].exp_np));
      check($sformatf("vec%0d last_x", v),  35'(last_x),  35'(vt[v].exp_last_x));
      check($sformatf("vec%0d first_p", v), 35'(first_p), 35'(vt[v].exp_first_p));
      check($sformatf("vec%0d last_p", v),  35'(last_p),  35'(vt[v].exp_last_p));
    end

    // Randomized passes with random ofifo_valid stalls
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 512; c++) valid_pat[c] = (c >= 400) || ($urandom_range(0, 9) < 7);
      run_pass(1'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
               AW'($urandom_range(0, 40)), $sformatf("rnd%0d", r),
               total, n_x, n_p, last_x, first_p, last_p);
    end

    // Reset in the middle of EXEC
    ofifo_valid = 1'b1;
    @(negedge clk);
    mode = 1'b1; kbase = 11'd3; abase = 11'd50; pbase = 11'd60; act_len = 11'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    check("midpass execute strobe", 35'(inst[1]), 35'(1));
    #2;
    reset = 1'b0;
    #1;
    check("midreset inst", inst, IDLE_W);
    check("midreset busy", 35'(busy), 35'(0));
    check("midreset done", 35'(done), 35'(0));
    @(negedge clk);
    reset = 1'b1;

    // Fresh pass; a second start while busy must be ignored
    @(negedge clk);
    mode = 1'b0; kbase = 11'd0; abase = 11'd8; pbase = 11'd20; act_len = 11'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0;
    first_done = -1;
    for (int c = 0; c < 120; c++) begin
      if (c == 3) begin act_len = 11'd5; start = 1'b1; end
      if (c == 4) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = c + 1;
      end
    end
    check("busy start done count", 35'(done_cnt), 35'(1));
    check("busy start done cycle", 35'(first_done), 35'(34));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
